// File: rtl/input_port_buffer.sv
// Router input FIFO with show-ahead head flit and XY route label; flit visible one cycle after push.
// Backpressure: full holds upstream off; pop only when the switch allocator grants and buffer is non-empty.
module input_port_buffer #(
  parameter int         DEPTH    = 8,
  parameter int         WIDTH    = 3,
  parameter int         DATASIZE = 40,
  parameter logic [1:0] LOCAL_X  = 2'd0,
  parameter logic [1:0] LOCAL_Y  = 2'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                data_valid,
  output logic                full,
  input  logic                ready,
  output logic [3:0]          label,
  output logic [DATASIZE-1:0] data_out,
  output logic [WIDTH:0]      count
);

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
  } node_t;

  localparam logic [WIDTH:0]   DEPTH_C  = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH-1:0] LAST_PTR = WIDTH'(DEPTH - 1);

  localparam logic [3:0] LBL_W     = 4'b1000;
  localparam logic [3:0] LBL_N     = 4'b0100;
  localparam logic [3:0] LBL_E     = 4'b0010;
  localparam logic [3:0] LBL_S     = 4'b0001;
  localparam logic [3:0] LBL_LOCAL = 4'b0000;
  localparam logic [3:0] LBL_NONE  = 4'b1111;

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH-1:0]    rd_ptr;
  logic                empty;
  logic                push;
  logic                pop;
  node_t               head_dst;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = data_valid && !full;
  assign pop   = ready && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left uncleared on reset; empty masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  assign data_out = empty ? '0 : mem[rd_ptr];
  assign head_dst = data_out[DATASIZE-5 -: 4];

  // Dimension-order routing: resolve X before Y.
  always_comb begin
    label = LBL_LOCAL;
    if (empty)                     label = LBL_NONE;
    else if (head_dst.x > LOCAL_X) label = LBL_E;
    else if (head_dst.x < LOCAL_X) label = LBL_W;
    else if (head_dst.y > LOCAL_Y) label = LBL_N;
    else if (head_dst.y < LOCAL_Y) label = LBL_S;
  end

endmodule
